// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | clk_div_pkg : shared encodings for the multi-channel divider    |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package clk_div_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } os_state_e;

endpackage
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// +----------------------------------------------------------------+
// | clk_div_ch : one divider/timer channel (periodic or one-shot)   |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module clk_div_ch #(
  parameter int CNT_W = 20
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic             iMode,
  input  logic [CNT_W-1:0] iDiv,
  input  logic             iStart,
  output logic             oDivClk,
  output logic             oTick,
  output logic             oBusy
);
  import clk_div_pkg::*;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_mode;
  os_state_e        r_state;
  logic             r_divclk;
  logic             r_tick;
  logic             r_busy;

  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_div;
  logic             w_mode;
  os_state_e        w_state;
  logic             w_divclk;
  logic             w_tick;
  logic             w_busy;
  logic             w_term;

  // The counter never passes r_div, so the increment below cannot wrap.
  assign w_term = (r_cnt == r_div);

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_cnt    <= '0;
      r_div    <= '0;
      r_mode   <= MODE_PERIODIC;
      r_state  <= IDLE;
      r_divclk <= 1'b0;
      r_tick   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt;
      r_div    <= w_div;
      r_mode   <= w_mode;
      r_state  <= w_state;
      r_divclk <= w_divclk;
      r_tick   <= w_tick;
      r_busy   <= w_busy;
    end
  end

  always_comb begin
    w_cnt    = r_cnt;
    w_div    = r_div;
    w_mode   = r_mode;
    w_state  = r_state;
    w_divclk = r_divclk;
    w_tick   = 1'b0;
    w_busy   = r_busy;

    if (!iEn || (iMode != r_mode)) begin
      // A disabled channel or a mode switch spends this cycle cleared.
      w_cnt    = '0;
      w_div    = iDiv;
      w_mode   = iMode;
      w_state  = IDLE;
      w_divclk = 1'b0;
      w_busy   = 1'b0;
    end else if (r_mode == MODE_PERIODIC) begin
      w_state = IDLE;
      w_busy  = 1'b0;
      if (iStart) begin
        w_cnt    = '0;
        w_div    = iDiv;
        w_divclk = 1'b0;
      end else if (w_term) begin
        // New divide values are adopted only at a wrap to avoid short halves.
        w_cnt    = '0;
        w_div    = iDiv;
        w_divclk = ~r_divclk;
        w_tick   = 1'b1;
      end else begin
        w_cnt = r_cnt + CNT_W'(1);
      end
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt = '0;
          if (iStart) begin
            w_div    = iDiv;
            w_divclk = 1'b1;
            w_busy   = 1'b1;
            w_state  = RUN;
          end else begin
            w_divclk = 1'b0;
            w_busy   = 1'b0;
          end
        end
        RUN: begin
          if (iStart) begin
            // Retrigger beats a coincident terminal count.
            w_cnt = '0;
            w_div = iDiv;
          end else if (w_term) begin
            w_divclk = 1'b0;
            w_busy   = 1'b0;
            w_tick   = 1'b1;
            w_state  = IDLE;
          end else begin
            w_cnt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end
  end

  assign oDivClk = r_divclk;
  assign oTick   = r_tick;
  assign oBusy   = r_busy;

endmodule
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// +----------------------------------------------------------------+
// | clk_div_multi : NUM_CH independent programmable dividers/timers |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module clk_div_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic [NUM_CH-1:0]       iEn,
  input  logic [NUM_CH-1:0]       iMode,
  input  logic [NUM_CH*CNT_W-1:0] iDiv,
  input  logic [NUM_CH-1:0]       iStart,
  output logic [NUM_CH-1:0]       oDivClk,
  output logic [NUM_CH-1:0]       oTick,
  output logic [NUM_CH-1:0]       oBusy
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iEn     (iEn[g]),
      .iMode   (iMode[g]),
      .iDiv    (iDiv[g*CNT_W +: CNT_W]),
      .iStart  (iStart[g]),
      .oDivClk (oDivClk[g]),
      .oTick   (oTick[g]),
      .oBusy   (oBusy[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_clk_div_multi : scoreboard bench with a cycle-level model    |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module tb_clk_div_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 20;
  localparam int DMAX   = (1 << CNT_W) - 1;

  logic                    iClk = 1'b0;
  logic                    iRst_n;
  logic [NUM_CH-1:0]       iEn, iMode, iStart;
  logic [NUM_CH*CNT_W-1:0] iDiv;
  logic [NUM_CH-1:0]       oDivClk, oTick, oBusy;

  clk_div_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iEn     (iEn),
    .iMode   (iMode),
    .iDiv    (iDiv),
    .iStart  (iStart),
    .oDivClk (oDivClk),
    .oTick   (oTick),
    .oBusy   (oBusy)
  );

  always #5 iClk = ~iClk;

  logic [3*NUM_CH-1:0] q[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  // Stimulus intent per channel
  bit rst;
  bit en[NUM_CH], mode[NUM_CH], start[NUM_CH];
  int div[NUM_CH];

  // Model: level, cycles left in current half period / pulse, running flag
  bit     m_mode[NUM_CH], m_run[NUM_CH], m_lvl[NUM_CH], m_tick[NUM_CH], m_busy[NUM_CH];
  longint m_left[NUM_CH];

  task automatic model_step(input int k);
    if (rst) begin
      m_mode[k] = 0; m_run[k] = 0; m_lvl[k] = 0; m_tick[k] = 0; m_busy[k] = 0;
      m_left[k] = 1;
    end else if (!en[k] || mode[k] != m_mode[k]) begin
      m_mode[k] = mode[k]; m_run[k] = 0; m_lvl[k] = 0; m_tick[k] = 0; m_busy[k] = 0;
      m_left[k] = longint'(div[k]) + 1;
    end else if (!m_mode[k]) begin
      m_busy[k] = 0;
      if (start[k]) begin
        m_lvl[k] = 0; m_tick[k] = 0; m_left[k] = longint'(div[k]) + 1;
      end else if (m_left[k] == 1) begin
        m_lvl[k] = !m_lvl[k]; m_tick[k] = 1; m_left[k] = longint'(div[k]) + 1;
      end else begin
        m_left[k]--; m_tick[k] = 0;
      end
    end else if (!m_run[k]) begin
      m_tick[k] = 0;
      if (start[k]) begin
        m_run[k] = 1; m_lvl[k] = 1; m_busy[k] = 1; m_left[k] = longint'(div[k]) + 1;
      end else begin
        m_lvl[k] = 0; m_busy[k] = 0;
      end
    end else if (start[k]) begin
      m_left[k] = longint'(div[k]) + 1; m_tick[k] = 0;
    end else if (m_left[k] == 1) begin
      m_run[k] = 0; m_lvl[k] = 0; m_busy[k] = 0; m_tick[k] = 1;
    end else begin
      m_left[k]--; m_tick[k] = 0;
    end
  endtask

  task automatic cycle(input int n);
    logic [NUM_CH-1:0] c, t, b;
    for (int i = 0; i < n; i++) begin
      iRst_n = !rst;
      for (int k = 0; k < NUM_CH; k++) begin
        iEn[k]    = en[k];
        iMode[k]  = mode[k];
        iStart[k] = start[k];
        iDiv[k*CNT_W +: CNT_W] = CNT_W'(div[k]);
        model_step(k);
        c[k] = m_lvl[k]; t[k] = m_tick[k]; b[k] = m_busy[k];
      end
      q.push_back({c, t, b});
      @(negedge iClk);
    end
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1; cycle(1); start[k] = 0;
  endtask

  initial begin : monitor
    logic [3*NUM_CH-1:0] e;
    forever begin
      @(posedge iClk);
      #1;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t got %b required an expectation", $time,
                 {oDivClk, oTick, oBusy});
      end else begin
        e = q.pop_front();
        if ({oDivClk, oTick, oBusy} !== e) begin
          errors++;
          $display("FAIL %s t=%0t got clk=%b tick=%b busy=%b required clk=%b tick=%b busy=%b",
                   phase, $time, oDivClk, oTick, oBusy,
                   e[3*NUM_CH-1 -: NUM_CH], e[2*NUM_CH-1 -: NUM_CH], e[NUM_CH-1:0]);
        end
      end
    end
  end

  initial begin : driver
    rst = 1;
    for (int k = 0; k < NUM_CH; k++) begin
      en[k] = 0; mode[k] = 0; start[k] = 0; div[k] = 0;
    end
    cycle(3);

    phase = "periodic_div3_div0_wide";
    rst = 0;
    en[0] = 1; div[0] = 3;
    en[1] = 1; div[1] = 0;
    en[2] = 1; mode[2] = 1; div[2] = 5;
    en[3] = 1; div[3] = DMAX;
    cycle(21);

    phase = "div_change_mid_period";
    div[1] = 2;
    cycle(15);

    phase = "oneshot_retrigger";
    pulse_start(2);
    cycle(2);
    pulse_start(2);
    cycle(14);
    pulse_start(2);
    cycle(10);

    phase = "periodic_resync";
    cycle(2);
    pulse_start(0);
    cycle(10);

    phase = "clear_en_mode";
    pulse_start(2);
    cycle(2);
    en[2] = 0; cycle(1); en[2] = 1;
    cycle(3);
    mode[0] = 1; cycle(2); mode[0] = 0;
    cycle(6);

    phase = "reset_mid_run";
    pulse_start(2);
    cycle(2);
    rst = 1; cycle(1); rst = 0;
    cycle(12);

    phase = "random";
    for (int i = 0; i < 30000; i++) begin
      rst = ($urandom_range(0, 4999) == 0);
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 199) == 0) en[k] = !en[k];
        if ($urandom_range(0, 299) == 0) mode[k] = !mode[k];
        if ($urandom_range(0, 49) == 0)
          div[k] = (k == 3) ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : DMAX)
                            : int'($urandom_range(0, 9));
        start[k] = ($urandom_range(0, 24) == 0);
      end
      cycle(1);
    end

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
